id_stage_hz: RTL and testbench
==============================

# id_stage_hz

Parametrised instruction-decode stage for the pipelined MIPS core: register file (2 read, 1 write) with same-cycle write-through bypass, immediate extension, load-use hazard detection with bubble insertion, and downstream stall/flush handling. Sits between fetch/branch-predictor and execute/forwarding. The writeback port (stage 5) shares this block's register file.

## Interface
Parameters:
- DATA_W, 32: register and operand width.
- NREGS, 32: number of architectural registers; AW = $clog2(NREGS). R0 is hard-wired to 0.
- IMM_W, 16: raw immediate width; must be ≤ DATA_W.
- TYPE_W, 4: instruction-type code width.
- CNT_W, 16: width of the stall counter.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- done_in_ID / done_in_WB  in  1  end-of-program markers from IF and MEM.
- wb_en  in  1  writeback enable.
- wb_addr  in  AW  writeback register.
- wb_data  in  DATA_W  writeback value.
- has_rs, has_rt, has_rd, has_imm  in  1  field-valid flags.
- rs, rt, rd  in  AW  register fields.
- imm  in  IMM_W  raw immediate.
- imm_zext  in  1  1 = zero-extend imm, 0 = sign-extend.
- instr_type_IF  in  TYPE_W  type code; 0 = nop.
- ex_stall  in  1  downstream hold.
- flush  in  1  mispredict kill.
- A, B  out  DATA_W  signed operands.
- sourceA, sourceB  out  AW  operand source registers (0 = none/immediate).
- wb_tgt_ID  out  AW  destination register (0 = none).
- instr_type_ID  out  TYPE_W  registered type.
- sw_offset  out  IMM_W  store offset.
- done_ID, done_WB  out  1  registered done flags.
- hazard_stall  out  1  combinational; IF must hold its outputs.
- stall_cnt  out  CNT_W  count of bubbles inserted by hazards.

## Operation
- Reset: all outputs and all registers are set to 0. hazard_stall is 0 while reset is high.
- Writeback runs every non-reset cycle, regardless of stall or flush:
  - if wb_en and wb_addr≠0, then reg[wb_addr] ← wb_data.
  - done_WB ← done_in_WB.
- Read: the value of register r is 0 if r=0. Otherwise it is wb_data if wb_en and wb_addr=r (bypass). Otherwise it is reg[r].
- Immediate extension: immx = imm extended to DATA_W, zero- or sign-extended per imm_zext.
- Hazard: hazard_stall = (instr_type_ID=T_LOAD) && wb_tgt_ID≠0 && instr_type_IF≠0 && ((has_rs && rs=wb_tgt_ID) || (has_rt && rt=wb_tgt_ID)), gated by !ex_stall.
- Per-cycle priority for the ID register set:
  1. reset
  2. flush: load a bubble.
  3. ex_stall: hold every ID output.
  4. hazard_stall: load a bubble and increment stall_cnt (saturating).
  5. Otherwise: decode.
- Bubble: instr_type_ID, wb_tgt_ID, sourceA, sourceB and done_ID are set to 0. A, B and sw_offset are don't-care and are held.
- Decode (instr_type_IF≠0):
  - A ← read(rs); sourceA ← rs.
  - If type is T_STORE: B ← read(rt), sourceB ← rt, wb_tgt_ID ← 0, sw_offset ← imm.
  - Else if has_imm: B ← immx, sourceB ← 0, wb_tgt_ID ← rt.
  - Else: B ← read(rt), sourceB ← rt, wb_tgt_ID ← rd.
  - In all cases instr_type_ID ← instr_type_IF and done_ID ← done_in_ID.
- Decode with instr_type_IF=0: instr_type_ID ← 0 and wb_tgt_ID ← 0; done_ID ← done_in_ID. Other outputs are held.

## Timing
- ID latency is 1 cycle; writeback takes effect at the same edge.
- A read in cycle N of a register written in cycle N returns the new value via the bypass.
- A load-use pair costs exactly one bubble:
  - Cycle N: hazard_stall=1.
  - Cycle N+1: the dependent instruction is re-presented. instr_type_ID is now 0, so there is no hazard and it decodes.
- Flush and hazard in the same cycle: flush wins. stall_cnt does not increment.
- ex_stall and flush in the same cycle: flush wins.
- stall_cnt saturates at all-ones and is cleared only by reset.
- Reset asserted mid-stall: all outputs are 0 on the next edge.

## Structure
- Package id_pkg holds the type codes: T_NOP=0, T_LOAD=13, T_STORE=14, plus a helper function for imm extension.
- One sub-module, regfile_2r1w: parametrised on DATA_W and NREGS, with synchronous write, combinational read, bypass and R0 forcing.
- Hazard logic, the priority mux and the counter live in id_stage_hz.

## Test plan
- Bypass: wb_en=1, wb_addr=5, wb_data=0xDEAD with an R-type rs=5, rt=0, rd=3 in the same cycle → A=0xDEAD, B=0, wb_tgt_ID=3 next cycle.
- Imm extension: imm=0xFFF0 with has_imm=1, imm_zext=0 → B=0xFFFFFFF0. With imm_zext=1 → B=0x0000FFF0. In both cases wb_tgt_ID=rt.
- Load-use: a load to R7 followed by an add with rs=7 → hazard_stall=1 for one cycle, one bubble (instr_type_ID=0), then the add decodes, and stall_cnt=1.
- Flush plus hazard in the same cycle → bubble, stall_cnt unchanged, hazard clears next cycle.
- ex_stall=1 for 3 cycles while the IF inputs change → all ID outputs are held, while writeback to R9=0x55 still lands. After release, reading R9 returns 0x55.
- R0 and reset: a write to R0 with 0x1234 reads back as 0. Asserting reset for one cycle mid-sequence → every output is 0 and stall_cnt=0.

Source files
------------

// File: rtl/id_pkg.sv
// Shared type codes and immediate-extension helper for the decode stage.
package id_pkg;

    localparam int T_NOP   = 0;
    localparam int T_LOAD  = 13;
    localparam int T_STORE = 14;

    // Extends the low 'width' bits of raw to 64 bits; callers truncate to their data width.
    function automatic logic [63:0] ext_imm(input logic [63:0] raw,
                                            input int unsigned width,
                                            input logic zext);
        logic [63:0] res;
        logic        fill;
        fill = zext ? 1'b0 : raw[6'(width - 1)];
        for (int i = 0; i < 64; i++) begin
            res[i] = (i < int'(width)) ? raw[i] : fill;
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file. R0 reads as zero; a same-cycle write is bypassed to the reads.
module regfile_2r1w #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr_a,
    input  logic [AW-1:0]     rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b
);

    logic [DATA_W-1:0] regs [NREGS];

    // Storage write; R0 is never written so it stays zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && wr_addr != '0) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read ports with R0 forcing and write-through bypass.
    always_comb begin
        rd_data_a = regs[rd_addr_a];
        rd_data_b = regs[rd_addr_b];
        if (wr_en && wr_addr == rd_addr_a) rd_data_a = wr_data;
        if (wr_en && wr_addr == rd_addr_b) rd_data_b = wr_data;
        if (rd_addr_a == '0) rd_data_a = '0;
        if (rd_addr_b == '0) rd_data_b = '0;
    end

endmodule

// File: rtl/id_stage_hz.sv
// Decode stage: operand fetch, immediate extension, load-use bubble insertion, stall/flush handling.
module id_stage_hz
    import id_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int IMM_W  = 16,
    parameter int TYPE_W = 4,
    parameter int CNT_W  = 16,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     done_in_ID,
    input  logic                     done_in_WB,
    input  logic                     wb_en,
    input  logic [AW-1:0]            wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     has_rs,
    input  logic                     has_rt,
    input  logic                     has_rd,
    input  logic                     has_imm,
    input  logic [AW-1:0]            rs,
    input  logic [AW-1:0]            rt,
    input  logic [AW-1:0]            rd,
    input  logic [IMM_W-1:0]         imm,
    input  logic                     imm_zext,
    input  logic [TYPE_W-1:0]        instr_type_IF,
    input  logic                     ex_stall,
    input  logic                     flush,
    output logic signed [DATA_W-1:0] A,
    output logic signed [DATA_W-1:0] B,
    output logic [AW-1:0]            sourceA,
    output logic [AW-1:0]            sourceB,
    output logic [AW-1:0]            wb_tgt_ID,
    output logic [TYPE_W-1:0]        instr_type_ID,
    output logic [IMM_W-1:0]         sw_offset,
    output logic                     done_ID,
    output logic                     done_WB,
    output logic                     hazard_stall,
    output logic [CNT_W-1:0]         stall_cnt
);

    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] immx;
    logic              use_hit;
    logic              load_in_id;

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_rf (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wb_en),
        .wr_addr   (wb_addr),
        .wr_data   (wb_data),
        .rd_addr_a (rs),
        .rd_addr_b (rt),
        .rd_data_a (rs_val),
        .rd_data_b (rt_val)
    );

    assign immx = DATA_W'(ext_imm(64'(imm), IMM_W, imm_zext));

    // A load sitting in ID whose destination is a source of the instruction in IF needs one bubble.
    assign load_in_id   = (instr_type_ID == TYPE_W'(T_LOAD)) && (wb_tgt_ID != '0);
    assign use_hit      = (has_rs && rs == wb_tgt_ID) || (has_rt && rt == wb_tgt_ID);
    assign hazard_stall = !reset && !ex_stall && load_in_id &&
                          (instr_type_IF != TYPE_W'(T_NOP)) && use_hit;

    // ID register set: flush > ex_stall hold > hazard bubble > decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            A             <= '0;
            B             <= '0;
            sourceA       <= '0;
            sourceB       <= '0;
            wb_tgt_ID     <= '0;
            instr_type_ID <= '0;
            sw_offset     <= '0;
            done_ID       <= 1'b0;
            stall_cnt     <= '0;
        end else if (flush) begin
            instr_type_ID <= '0;
            wb_tgt_ID     <= '0;
            sourceA       <= '0;
            sourceB       <= '0;
            done_ID       <= 1'b0;
        end else if (ex_stall) begin
            // hold everything
        end else if (hazard_stall) begin
            instr_type_ID <= '0;
            wb_tgt_ID     <= '0;
            sourceA       <= '0;
            sourceB       <= '0;
            done_ID       <= 1'b0;
            if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
        end else if (instr_type_IF != TYPE_W'(T_NOP)) begin
            A             <= rs_val;
            sourceA       <= rs;
            instr_type_ID <= instr_type_IF;
            done_ID       <= done_in_ID;
            if (instr_type_IF == TYPE_W'(T_STORE)) begin
                B         <= rt_val;
                sourceB   <= rt;
                wb_tgt_ID <= '0;
                sw_offset <= imm;
            end else if (has_imm) begin
                B         <= immx;
                sourceB   <= '0;
                wb_tgt_ID <= rt;
            end else begin
                B         <= rt_val;
                sourceB   <= rt;
                wb_tgt_ID <= rd;
            end
        end else begin
            instr_type_ID <= '0;
            wb_tgt_ID     <= '0;
            done_ID       <= done_in_ID;
        end
    end

    // Writeback-side done flag follows MEM every cycle, independent of stalls.
    always_ff @(posedge clk) begin
        if (reset) done_WB <= 1'b0;
        else       done_WB <= done_in_WB;
    end

endmodule

// File: tb/tb_id_stage_hz.sv
// Directed bench for id_stage_hz with a cycle-level reference model and literal pin checks.
module tb_id_stage_hz;
    import id_pkg::*;

    localparam int DATA_W = 32;
    localparam int NREGS  = 32;
    localparam int AW     = 5;
    localparam int IMM_W  = 16;
    localparam int TYPE_W = 4;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              done_in_ID, done_in_WB, wb_en;
    logic [AW-1:0]     wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              has_rs, has_rt, has_rd, has_imm;
    logic [AW-1:0]     rs, rt, rd;
    logic [IMM_W-1:0]  imm;
    logic              imm_zext;
    logic [TYPE_W-1:0] instr_type_IF;
    logic              ex_stall, flush;
    logic [DATA_W-1:0] A, B;
    logic [AW-1:0]     sourceA, sourceB, wb_tgt_ID;
    logic [TYPE_W-1:0] instr_type_ID;
    logic [IMM_W-1:0]  sw_offset;
    logic              done_ID, done_WB, hazard_stall;
    logic [CNT_W-1:0]  stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    id_stage_hz #(
        .DATA_W (DATA_W), .NREGS (NREGS), .IMM_W (IMM_W), .TYPE_W (TYPE_W), .CNT_W (CNT_W)
    ) dut (
        .clk (clk), .reset (reset), .done_in_ID (done_in_ID), .done_in_WB (done_in_WB),
        .wb_en (wb_en), .wb_addr (wb_addr), .wb_data (wb_data),
        .has_rs (has_rs), .has_rt (has_rt), .has_rd (has_rd), .has_imm (has_imm),
        .rs (rs), .rt (rt), .rd (rd), .imm (imm), .imm_zext (imm_zext),
        .instr_type_IF (instr_type_IF), .ex_stall (ex_stall), .flush (flush),
        .A (A), .B (B), .sourceA (sourceA), .sourceB (sourceB), .wb_tgt_ID (wb_tgt_ID),
        .instr_type_ID (instr_type_ID), .sw_offset (sw_offset), .done_ID (done_ID),
        .done_WB (done_WB), .hazard_stall (hazard_stall), .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] mregs [NREGS];
    logic [DATA_W-1:0] m_A, m_B;
    logic [AW-1:0]     m_srcA, m_srcB, m_tgt;
    logic [TYPE_W-1:0] m_type;
    logic [IMM_W-1:0]  m_off;
    logic              m_done_id, m_done_wb;
    int                m_cnt;
    bit                started = 0;

    function automatic logic [DATA_W-1:0] m_read(input logic [AW-1:0] r);
        if (r == '0) return '0;
        if (wb_en && wb_addr == r) return wb_data;
        return mregs[r];
    endfunction

    function automatic logic m_hazard();
        if (reset || ex_stall) return 1'b0;
        if (m_type != TYPE_W'(T_LOAD) || m_tgt == '0 || instr_type_IF == '0) return 1'b0;
        return (has_rs && rs == m_tgt) || (has_rt && rt == m_tgt);
    endfunction

    task automatic m_bubble();
        m_type = '0; m_tgt = '0; m_srcA = '0; m_srcB = '0; m_done_id = 1'b0;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) mregs[i] = '0;
            m_A = '0; m_B = '0; m_srcA = '0; m_srcB = '0; m_tgt = '0;
            m_type = '0; m_off = '0; m_done_id = 0; m_done_wb = 0; m_cnt = 0;
        end else begin
            if (flush) m_bubble();
            else if (ex_stall) begin end
            else if (m_hazard()) begin
                m_bubble();
                if (m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
            end else if (instr_type_IF != '0) begin
                m_A = m_read(rs); m_srcA = rs;
                m_type = instr_type_IF; m_done_id = done_in_ID;
                if (instr_type_IF == TYPE_W'(T_STORE)) begin
                    m_B = m_read(rt); m_srcB = rt; m_tgt = '0; m_off = imm;
                end else if (has_imm) begin
                    m_B = imm_zext ? DATA_W'(imm) : DATA_W'($signed(imm));
                    m_srcB = '0; m_tgt = rt;
                end else begin
                    m_B = m_read(rt); m_srcB = rt; m_tgt = rd;
                end
            end else begin
                m_type = '0; m_tgt = '0; m_done_id = done_in_ID;
            end
            m_done_wb = done_in_WB;
            if (wb_en && wb_addr != '0) mregs[wb_addr] = wb_data;
        end
        started = 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            check("A", 64'(A), 64'(m_A));
            check("B", 64'(B), 64'(m_B));
            check("sourceA", 64'(sourceA), 64'(m_srcA));
            check("sourceB", 64'(sourceB), 64'(m_srcB));
            check("wb_tgt_ID", 64'(wb_tgt_ID), 64'(m_tgt));
            check("instr_type_ID", 64'(instr_type_ID), 64'(m_type));
            check("sw_offset", 64'(sw_offset), 64'(m_off));
            check("done_ID", 64'(done_ID), 64'(m_done_id));
            check("done_WB", 64'(done_WB), 64'(m_done_wb));
            check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
            check("hazard_stall", 64'(hazard_stall), 64'(m_hazard()));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        done_in_ID = 0; done_in_WB = 0; wb_en = 0; wb_addr = '0; wb_data = '0;
        has_rs = 0; has_rt = 0; has_rd = 0; has_imm = 0;
        rs = '0; rt = '0; rd = '0; imm = '0; imm_zext = 0;
        instr_type_IF = '0; ex_stall = 0; flush = 0;
    endtask

    task automatic instr(input int t, input logic hrs, input logic hrt, input logic hrd,
                         input logic himm, input int rs_i, input int rt_i, input int rd_i,
                         input logic [IMM_W-1:0] im, input logic z);
        instr_type_IF = TYPE_W'(t);
        has_rs = hrs; has_rt = hrt; has_rd = hrd; has_imm = himm;
        rs = AW'(rs_i); rt = AW'(rt_i); rd = AW'(rd_i); imm = im; imm_zext = z;
    endtask

    task automatic load_r7();
        instr(T_LOAD, 1, 0, 0, 1, 5, 7, 0, 16'h0004, 0);
    endtask

    task automatic add_use_r7();
        instr(2, 1, 1, 1, 0, 7, 1, 8, 16'h0000, 0);
    endtask

    initial begin
        clr();
        reset = 1;
        step(); step();
        reset = 0;
        check("lit_reset_cnt", 64'(stall_cnt), 64'd0);
        check("lit_reset_A", 64'(A), 64'd0);
        check("lit_reset_type", 64'(instr_type_ID), 64'd0);
        check("lit_reset_hz", 64'(hazard_stall), 64'd0);

        // same-cycle bypass
        wb_en = 1; wb_addr = 5; wb_data = 32'hDEAD; done_in_WB = 1; done_in_ID = 1;
        instr(2, 1, 1, 1, 0, 5, 0, 3, 16'h0000, 0);
        step();
        check("lit_bypass_A", 64'(A), 64'h0000_DEAD);
        check("lit_bypass_B", 64'(B), 64'd0);
        check("lit_bypass_tgt", 64'(wb_tgt_ID), 64'd3);
        check("lit_done_WB", 64'(done_WB), 64'd1);
        clr();
        instr(2, 1, 1, 1, 0, 5, 5, 4, 16'h0000, 0);
        step();
        check("lit_rf_B", 64'(B), 64'h0000_DEAD);

        // immediate extension
        instr(3, 1, 0, 0, 1, 5, 6, 0, 16'hFFF0, 0);
        step();
        check("lit_sext_B", 64'(B), 64'hFFFF_FFF0);
        check("lit_sext_tgt", 64'(wb_tgt_ID), 64'd6);
        instr(3, 1, 0, 0, 1, 5, 11, 0, 16'hFFF0, 1);
        step();
        check("lit_zext_B", 64'(B), 64'h0000_FFF0);
        check("lit_zext_tgt", 64'(wb_tgt_ID), 64'd11);

        // nop in IF
        clr();
        step();
        check("lit_nop_type", 64'(instr_type_ID), 64'd0);
        check("lit_nop_A_held", 64'(A), 64'h0000_DEAD);

        // load-use: one bubble
        load_r7(); step();
        add_use_r7(); #1;
        check("lit_lu_hz", 64'(hazard_stall), 64'd1);
        step();
        check("lit_lu_bubble", 64'(instr_type_ID), 64'd0);
        check("lit_lu_cnt", 64'(stall_cnt), 64'd1);
        check("lit_lu_hz_clear", 64'(hazard_stall), 64'd0);
        step();
        check("lit_lu_decode", 64'(wb_tgt_ID), 64'd8);

        // flush and hazard together
        load_r7(); step();
        add_use_r7(); flush = 1; #1;
        check("lit_fh_hz", 64'(hazard_stall), 64'd1);
        step();
        check("lit_fh_bubble", 64'(instr_type_ID), 64'd0);
        check("lit_fh_cnt", 64'(stall_cnt), 64'd1);
        flush = 0; #1;
        check("lit_fh_hz_clear", 64'(hazard_stall), 64'd0);
        step();

        // ex_stall hold with writeback landing
        load_r7(); step();
        ex_stall = 1; wb_en = 1; wb_addr = 9; wb_data = 32'h55;
        add_use_r7(); #1;
        check("lit_stall_hz_gated", 64'(hazard_stall), 64'd0);
        step();
        wb_en = 0; instr(3, 1, 0, 0, 1, 2, 4, 0, 16'h1234, 0); step();
        instr(T_STORE, 1, 1, 0, 1, 3, 4, 0, 16'h0008, 0); step();
        check("lit_stall_type", 64'(instr_type_ID), 64'd13);
        check("lit_stall_tgt", 64'(wb_tgt_ID), 64'd7);
        ex_stall = 0;
        instr(2, 1, 1, 1, 0, 9, 7, 12, 16'h0000, 0); #1;
        check("lit_release_hz", 64'(hazard_stall), 64'd1);
        step();
        check("lit_release_cnt", 64'(stall_cnt), 64'd2);
        step();
        check("lit_r9", 64'(A), 64'h55);

        // store
        instr(T_STORE, 1, 1, 0, 1, 9, 5, 0, 16'h0040, 0);
        step();
        check("lit_st_B", 64'(B), 64'h0000_DEAD);
        check("lit_st_tgt", 64'(wb_tgt_ID), 64'd0);
        check("lit_st_off", 64'(sw_offset), 64'h40);

        // R0 stays zero
        wb_en = 1; wb_addr = 0; wb_data = 32'h1234;
        instr(2, 1, 1, 1, 0, 0, 0, 13, 16'h0000, 0);
        step();
        check("lit_r0_bypass", 64'(A), 64'd0);
        wb_en = 0;
        step();
        check("lit_r0_read", 64'(A), 64'd0);

        // counter saturation
        for (int k = 0; k < 16; k++) begin
            load_r7(); step();
            add_use_r7(); step();
            step();
        end
        check("lit_sat_cnt", 64'(stall_cnt), 64'd15);

        // reset in the middle of a stall
        load_r7(); step();
        add_use_r7(); #1;
        check("lit_pre_rst_hz", 64'(hazard_stall), 64'd1);
        reset = 1; #1;
        check("lit_rst_hz", 64'(hazard_stall), 64'd0);
        step();
        check("lit_rst_cnt", 64'(stall_cnt), 64'd0);
        check("lit_rst_tgt", 64'(wb_tgt_ID), 64'd0);
        check("lit_rst_B", 64'(B), 64'd0);
        reset = 0;
        instr(2, 1, 1, 1, 0, 9, 5, 3, 16'h0000, 0);
        step();
        check("lit_rst_r9", 64'(A), 64'd0);
        check("lit_rst_r5", 64'(B), 64'd0);

        clr();
        step();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
